// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg : shared types and constants for the instruction fetch   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : PC, imem req/ack fetch, skid buffer for stalls        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] PCAdderOut,
  output logic [31:0] InstructionOut,
  output logic        FetchValid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;

  logic         ack;
  logic [31:0]  pc_inc;
  logic [31:0]  target_pc;

  assign IMemReq        = (state_q != HELD);
  assign IMemAddr       = req_addr_q;
  assign PCAdderOut     = pc_out_q;
  assign InstructionOut = instr_q;
  assign FetchValid     = valid_q;

  assign ack       = IMemAck & IMemReq;
  assign pc_inc    = pc_q + PC_INC;
  assign target_pc = {RedirectPC[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    if (Redirect) begin
      // An un-acked request cannot be withdrawn, so it is drained first.
      pc_d     = target_pc;
      valid_d  = 1'b0;
      buf_d    = '0;
      buf_pc_d = '0;
      if ((state_q == HELD) || ack) begin
        req_addr_d = target_pc;
        state_d    = FETCH;
      end else begin
        state_d    = DRAIN;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack && !Stall) begin
            pc_out_d   = pc_inc;
            instr_d    = IMemData;
            valid_d    = 1'b1;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
          end else if (ack && Stall) begin
            buf_d      = IMemData;
            buf_pc_d   = pc_inc;
            pc_d       = pc_inc;
            req_addr_d = pc_inc;
            state_d    = HELD;
          end else if (!Stall) begin
            valid_d    = 1'b0;
          end
        end
        HELD: begin
          if (!Stall) begin
            pc_out_d = buf_pc_q;
            instr_d  = buf_q;
            valid_d  = 1'b1;
            state_d  = FETCH;
          end
        end
        DRAIN: begin
          if (ack) begin
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      buf_q      <= '0;
      buf_pc_q   <= '0;
      pc_out_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench with addr-as-data instruction mem |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck = 1'b0;
  logic [31:0] IMemData = '0;
  logic [31:0] PCAdderOut;
  logic [31:0] InstructionOut;
  logic        FetchValid;

  int          checks = 0;
  int          errors = 0;
  int          wait_states = 0;
  logic [63:0] exp_q[$];

  always #5 Clk = ~Clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .IMemReq        (IMemReq),
    .IMemAddr       (IMemAddr),
    .IMemAck        (IMemAck),
    .IMemData       (IMemData),
    .PCAdderOut     (PCAdderOut),
    .InstructionOut (InstructionOut),
    .FetchValid     (FetchValid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic expect_out(input logic [31:0] pc4, input logic [31:0] instr);
    exp_q.push_back({pc4, instr});
  endtask

  // Instruction memory: data = address, Ack after wait_states idle cycles.
  initial begin
    int          cnt;
    logic        prev_pending;
    logic [31:0] prev_addr;
    cnt = 0;
    prev_pending = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        IMemAck = 1'b0;
        cnt = 0;
        prev_pending = 1'b0;
      end else begin
        if (prev_pending) chk("addr_stable", IMemAddr, prev_addr);
        if (IMemReq) begin
          if (cnt >= wait_states) begin
            IMemAck  = 1'b1;
            IMemData = IMemAddr;
            cnt = 0;
          end else begin
            IMemAck = 1'b0;
            cnt++;
          end
        end else begin
          IMemAck = 1'b0;
          cnt = 0;
        end
        prev_pending = IMemReq && !IMemAck;
        prev_addr = IMemAddr;
      end
    end
  end

  // Monitor: a new instruction is presented on any edge without Stall that leaves FetchValid high.
  initial begin
    logic        s;
    logic        r;
    logic [63:0] e;
    forever begin
      @(posedge Clk);
      s = Stall;
      r = Rst_n;
      #1;
      if (r && Rst_n && !s && FetchValid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h/%h expected none", PCAdderOut, InstructionOut);
        end else begin
          e = exp_q.pop_front();
          if ({PCAdderOut, InstructionOut} !== e) begin
            errors++;
            $display("FAIL fetch_out: got %h/%h expected %h/%h",
                     PCAdderOut, InstructionOut, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:5]  vpat;
    logic [31:0] apat[6];
    vpat = 6'b001001;
    apat = '{32'd12, 32'd12, 32'd16, 32'd16, 32'd16, 32'd20};

    Rst_n = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    RedirectPC = '0;
    wait_states = 0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_valid", {31'd0, FetchValid}, 32'd0);
    chk("rst_pcout", PCAdderOut, 32'd0);
    chk("rst_instr", InstructionOut, 32'd0);
    chk("rst_addr", IMemAddr, 32'd0);

    // Zero-wait streaming
    @(posedge Clk);
    #2;
    expect_out(32'd4, 32'd0);
    expect_out(32'd8, 32'd4);
    expect_out(32'd12, 32'd8);
    Rst_n = 1'b1;
    repeat (3) step();

    // Two wait states per fetch
    wait_states = 2;
    expect_out(32'd16, 32'd12);
    expect_out(32'd20, 32'd16);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("wait_valid", {31'd0, FetchValid}, {31'd0, vpat[i]});
      chk("wait_addr", IMemAddr, apat[i]);
    end

    // Stall in the ack cycle, held for three cycles
    wait_states = 0;
    Stall = 1'b1;
    expect_out(32'd24, 32'd20);
    expect_out(32'd28, 32'd24);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_req", {31'd0, IMemReq}, 32'd0);
      chk("held_pcout", PCAdderOut, 32'd20);
      chk("held_instr", InstructionOut, 32'd16);
      chk("held_valid", {31'd0, FetchValid}, 32'd1);
    end
    Stall = 1'b0;
    step();
    chk("resume_req", {31'd0, IMemReq}, 32'd1);
    chk("resume_addr", IMemAddr, 32'd24);
    step();

    // Redirect during a two-wait-state fetch
    wait_states = 2;
    Redirect = 1'b1;
    RedirectPC = 32'h0000_0103;
    expect_out(32'h0000_0104, 32'h0000_0100);
    step();
    Redirect = 1'b0;
    chk("drain_valid0", {31'd0, FetchValid}, 32'd0);
    chk("drain_addr0", IMemAddr, 32'd28);
    chk("drain_req", {31'd0, IMemReq}, 32'd1);
    step();
    chk("drain_valid1", {31'd0, FetchValid}, 32'd0);
    chk("drain_addr1", IMemAddr, 32'd28);
    step();
    chk("redir_addr", IMemAddr, 32'h0000_0100);
    chk("redir_valid", {31'd0, FetchValid}, 32'd0);
    step();
    chk("redir_bubble0", {31'd0, FetchValid}, 32'd0);
    step();
    chk("redir_bubble1", {31'd0, FetchValid}, 32'd0);
    step();

    // Redirect together with Stall while HELD, target at top of address space
    wait_states = 0;
    Stall = 1'b1;
    step();
    chk("held2_req", {31'd0, IMemReq}, 32'd0);
    chk("held2_pcout", PCAdderOut, 32'h0000_0104);
    Redirect = 1'b1;
    RedirectPC = 32'hFFFF_FFFC;
    step();
    chk("hr_valid", {31'd0, FetchValid}, 32'd0);
    chk("hr_req", {31'd0, IMemReq}, 32'd1);
    chk("hr_addr", IMemAddr, 32'hFFFF_FFFC);
    Redirect = 1'b0;
    Stall = 1'b0;
    expect_out(32'h0000_0000, 32'hFFFF_FFFC);
    step();
    chk("wrap_pcout", PCAdderOut, 32'h0000_0000);
    wait_states = 2;
    expect_out(32'd4, 32'd0);
    repeat (3) step();

    // Reset pulsed while draining
    Redirect = 1'b1;
    RedirectPC = 32'h0000_0200;
    step();
    Redirect = 1'b0;
    chk("pre_rst_valid", {31'd0, FetchValid}, 32'd0);
    chk("pre_rst_addr", IMemAddr, 32'd4);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, FetchValid}, 32'd0);
    chk("mid_rst_pcout", PCAdderOut, 32'd0);
    chk("mid_rst_instr", InstructionOut, 32'd0);
    chk("mid_rst_addr", IMemAddr, 32'd0);
    chk("mid_rst_req", {31'd0, IMemReq}, 32'd1);
    wait_states = 0;
    repeat (2) @(posedge Clk);
    #2;
    expect_out(32'd4, 32'd0);
    Rst_n = 1'b1;
    step();
    wait_states = 1000;
    repeat (3) step();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
`default_nettype wire
